// File: rtl/query_parser_mq_pkg.sv
// Shared symbol codes, symbol classification and FSM encoding for the query parser.
package query_parser_mq_pkg;

  localparam int SYM_W = 3;
  localparam logic [SYM_W-1:0] SYM_END = 3'b000;
  localparam logic [SYM_W-1:0] SYM_SEP = 3'b001;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM, S_HOLD} state_t;
  typedef enum logic [1:0] {K_BASE, K_END, K_SEP} kind_t;

  // 1bb is a base; 000 ends the stream; 001 and the reserved 01x split queries.
  function automatic kind_t sym_kind(input logic [SYM_W-1:0] s);
    case (s)
      SYM_END: sym_kind = K_END;
      SYM_SEP: sym_kind = K_SEP;
      default: sym_kind = s[2] ? K_BASE : K_SEP;
    endcase
  endfunction

endpackage

// File: rtl/query_parser_mq_sym_word_buffer.sv
// Active symbol word plus one-word prefetch; exposes head symbol and one-symbol lookahead.
module query_parser_mq_sym_word_buffer
  import query_parser_mq_pkg::*;
#(
  parameter  int SYM_PER_WORD = 8,
  localparam int WORD_W       = SYM_W * SYM_PER_WORD,
  localparam int IDX_W        = (SYM_PER_WORD > 1) ? $clog2(SYM_PER_WORD) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              pop,
  input  logic              load_vld,
  input  logic [WORD_W-1:0] load_data,
  output logic [SYM_W-1:0]  head_sym,
  output logic              head_vld,
  output logic              next_vld,
  output logic              next_is_base,
  output logic              pf_vld_nxt
);

  logic [WORD_W-1:0] buf_q, pf_q, nxt_word;
  logic              buf_vld, pf_vld, at_last, wrap, to_buf;
  logic [IDX_W-1:0]  sym_idx;
  int                nxt_idx;

  assign at_last  = (sym_idx == IDX_W'(SYM_PER_WORD - 1));
  assign wrap     = pop && at_last;
  // Fresh data bypasses the prefetch slot when the active word is (or is about to be) empty.
  assign to_buf   = load_vld && (!buf_vld || (wrap && !pf_vld));

  assign head_vld = buf_vld;
  assign head_sym = buf_q[WORD_W-1-SYM_W*int'(sym_idx) -: SYM_W];

  assign nxt_word     = at_last ? pf_q : buf_q;
  assign nxt_idx      = at_last ? 0 : int'(sym_idx) + 1;
  assign next_is_base = nxt_word[WORD_W-1-SYM_W*nxt_idx];
  assign next_vld     = buf_vld && (!at_last || pf_vld);

  assign pf_vld_nxt = !flush && ((pf_vld && !wrap) || (load_vld && !to_buf));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q   <= '0;
      pf_q    <= '0;
      buf_vld <= 1'b0;
      pf_vld  <= 1'b0;
      sym_idx <= '0;
    end else if (flush) begin
      buf_vld <= 1'b0;
      pf_vld  <= 1'b0;
      sym_idx <= '0;
    end else begin
      if (to_buf) begin
        buf_q   <= load_data;
        buf_vld <= 1'b1;
        sym_idx <= '0;
      end else if (wrap) begin
        sym_idx <= '0;
        if (pf_vld) buf_q <= pf_q;
        else        buf_vld <= 1'b0;
      end else if (pop) begin
        sym_idx <= sym_idx + 1'b1;
      end
      if (load_vld && !to_buf) pf_q <= load_data;
      pf_vld <= pf_vld_nxt;
    end
  end

endmodule

// File: rtl/query_parser_mq.sv
// Query parser: fetches packed 3-bit symbols from SRAM and streams 2-bit bases to PE slots.
module query_parser_mq
  import query_parser_mq_pkg::*;
#(
  parameter  int PE_NUM       = 8,
  parameter  int SYM_PER_WORD = 8,
  parameter  int ADDR_W       = 16,
  parameter  int LEN_W        = 16,
  localparam int PE_BIT       = $clog2(PE_NUM),
  localparam int WORD_W       = SYM_W * SYM_PER_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              buffer_full_i,
  output logic              busy_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              request_o,
  input  logic [WORD_W-1:0] data_i,
  input  logic              valid_i,
  output logic [1:0]        q_out,
  output logic [PE_NUM-1:0] pe_valid_o,
  output logic              pouring_o,
  output logic              pouring_last_o,
  output logic              chunk_last_o,
  output logic              query_done_o,
  output logic [LEN_W-1:0]  query_len_o
);

  state_t            state, state_nxt;
  logic [PE_BIT-1:0] pe_idx, pe_idx_nxt;
  logic [LEN_W-1:0]  len_q, len_nxt;
  logic              end_seen, end_seen_nxt, req_nxt, got, pop, flush;
  logic              head_vld, next_vld, next_is_base, pf_vld_nxt;
  logic [SYM_W-1:0]  head_sym;
  logic              out_pour, out_last, out_done;
  logic [1:0]        out_q;

  function automatic logic has_end(input logic [WORD_W-1:0] w);
    has_end = 1'b0;
    for (int i = 0; i < SYM_PER_WORD; i++)
      if (w[SYM_W*i +: SYM_W] == SYM_END) has_end = 1'b1;
  endfunction

  assign got   = request_o && valid_i;
  assign flush = (state == S_IDLE);

  query_parser_mq_sym_word_buffer #(.SYM_PER_WORD(SYM_PER_WORD)) u_sym_word_buffer (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .pop          (pop),
    .load_vld     (got),
    .load_data    (data_i),
    .head_sym     (head_sym),
    .head_vld     (head_vld),
    .next_vld     (next_vld),
    .next_is_base (next_is_base),
    .pf_vld_nxt   (pf_vld_nxt)
  );

  always_comb begin
    state_nxt    = state;
    pe_idx_nxt   = pe_idx;
    len_nxt      = len_q;
    end_seen_nxt = end_seen;
    pop          = 1'b0;
    out_pour     = 1'b0;
    out_last     = 1'b0;
    out_done     = 1'b0;
    out_q        = '0;
    case (state)
      S_IDLE: if (start_i) begin
        state_nxt  = S_FILL;
        pe_idx_nxt = '0;
        len_nxt    = '0;
      end
      S_FILL: if (got) state_nxt = S_STREAM;
      S_STREAM: if (head_vld) begin
        if (sym_kind(head_sym) == K_BASE) begin
          // A base waits for its lookahead so chunk_last is known when it is emitted.
          if (next_vld) begin
            pop      = 1'b1;
            out_pour = 1'b1;
            out_q    = head_sym[1:0];
            len_nxt  = (&len_q) ? len_q : len_q + 1'b1;
            out_last = (pe_idx == PE_BIT'(PE_NUM - 1)) || !next_is_base;
            if (out_last) begin
              pe_idx_nxt = '0;
              state_nxt  = S_HOLD;
            end else begin
              pe_idx_nxt = pe_idx + 1'b1;
            end
          end
        end else begin
          pop        = 1'b1;
          out_done   = 1'b1;
          len_nxt    = '0;
          pe_idx_nxt = '0;
          state_nxt  = (sym_kind(head_sym) == K_END) ? S_IDLE : S_HOLD;
        end
      end
      S_HOLD: if (!buffer_full_i) state_nxt = S_STREAM;
      default: state_nxt = S_IDLE;
    endcase
    if (state == S_IDLE)            end_seen_nxt = 1'b0;
    else if (got && has_end(data_i)) end_seen_nxt = 1'b1;
    req_nxt = (state_nxt != S_IDLE) &&
              ((request_o && !valid_i) || (!end_seen_nxt && !pf_vld_nxt));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      pe_idx         <= '0;
      len_q          <= '0;
      end_seen       <= 1'b0;
      addr_o         <= '0;
      request_o      <= 1'b0;
      busy_o         <= 1'b0;
      q_out          <= '0;
      pe_valid_o     <= '0;
      pouring_o      <= 1'b0;
      pouring_last_o <= 1'b0;
      chunk_last_o   <= 1'b0;
      query_done_o   <= 1'b0;
      query_len_o    <= '0;
    end else begin
      state          <= state_nxt;
      pe_idx         <= pe_idx_nxt;
      len_q          <= len_nxt;
      end_seen       <= end_seen_nxt;
      request_o      <= req_nxt;
      busy_o         <= (state_nxt != S_IDLE);
      if (state == S_IDLE && start_i) addr_o <= base_addr_i;
      else if (got)                    addr_o <= addr_o + 1'b1;
      q_out          <= out_q;
      pe_valid_o     <= out_pour ? (PE_NUM'(1) << pe_idx) : '0;
      pouring_o      <= out_pour;
      pouring_last_o <= pouring_o;
      chunk_last_o   <= out_last;
      query_done_o   <= out_done;
      query_len_o    <= out_done ? len_q : '0;
    end
  end

endmodule
